// File: rtl/simd_drain.sv
// simd_drain: snapshots a completed accumulator tile and streams requantized elements one per beat.
module simd_drain #(
  parameter int DIM_A = 4,
  parameter int DIM_C = 4,
  parameter int IN_W  = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  localparam int CW = DIM_C > 1 ? $clog2(DIM_C) : 1,
  localparam int AW = DIM_A > 1 ? $clog2(DIM_A) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIM_C*DIM_A*IN_W-1:0]   acc_in,
  input  logic                          acc_valid,
  output logic [OUT_W-1:0]              out_data,
  output logic [CW-1:0]                 out_c,
  output logic [AW-1:0]                 out_a,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          drop_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam logic [IN_W:0] RND = SHIFT > 0 ? (IN_W+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  localparam logic [IN_W:0] MAX = (IN_W+1)'((1 << OUT_W) - 1);

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [AW-1:0]   a_q, a_d;
  logic            drop_q, drop_d;
  logic [IN_W-1:0] snap_q [DIM_C][DIM_A];
  logic [IN_W-1:0] snap_d [DIM_C][DIM_A];
  logic [IN_W-1:0] v;
  logic [IN_W:0]   r;
  logic            hs, fin, cap, last_a, last_c;

  always_comb begin
    last_a = a_q == AW'(DIM_A - 1);
    last_c = c_q == CW'(DIM_C - 1);
    hs = (state_q == STREAM) & out_ready;
    fin = hs & last_a & last_c;
    // a new tile is only accepted when idle or on the final handshake of the current one
    cap = acc_valid & ((state_q == IDLE) | fin);
    drop_d = drop_q | (acc_valid & (state_q == STREAM) & ~fin);
    state_d = cap ? STREAM : fin ? IDLE : state_q;
    a_d = cap ? '0 : hs ? (last_a ? '0 : a_q + AW'(1)) : a_q;
    c_d = cap ? '0 : (hs & last_a) ? (last_c ? '0 : c_q + CW'(1)) : c_q;
    snap_d = snap_q;
    for (int c = 0; c < DIM_C; c++)
      for (int a = 0; a < DIM_A; a++)
        if (cap) snap_d[c][a] = acc_in[(c*DIM_A+a)*IN_W +: IN_W];
    v = snap_q[c_q][a_q];
    r = ({1'b0, v} + RND) >> SHIFT;
    out_data = (r > MAX) ? '1 : r[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q <= '0;
      a_q <= '0;
      drop_q <= 1'b0;
      for (int c = 0; c < DIM_C; c++)
        for (int a = 0; a < DIM_A; a++)
          snap_q[c][a] <= '0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      a_q <= a_d;
      drop_q <= drop_d;
      snap_q <= snap_d;
    end
  end

  assign out_valid = state_q == STREAM;
  assign busy = out_valid;
  assign out_last = out_valid & last_a & last_c;
  assign out_c = c_q;
  assign out_a = a_q;
  assign drop_err = drop_q;
endmodule

// File: tb/tb_simd_drain.sv
// tb_simd_drain: scoreboard bench for simd_drain; stimulus queues expected beats, a monitor pops them.
module tb_simd_drain;
  logic clk = 0, rst, acc_valid, out_ready;
  logic [319:0] acc_in;
  logic [7:0] out_data;
  logic [1:0] out_c, out_a;
  logic out_valid, out_last, busy, drop_err;
  logic [319:0] acc0;
  logic av0, rdy0, v0, l0, b0, e0;
  logic [7:0] od0;
  logic [1:0] c0, a0;

  typedef struct packed {logic [7:0] d; logic [1:0] c; logic [1:0] a; logic l;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [19:0] el [16];
  logic [7:0] ex [16];
  logic stall_q = 0;
  exp_t held;

  simd_drain dut (.clk(clk), .rst(rst), .acc_in(acc_in), .acc_valid(acc_valid), .out_data(out_data),
    .out_c(out_c), .out_a(out_a), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .drop_err(drop_err));
  simd_drain #(.SHIFT(0)) u0 (.clk(clk), .rst(rst), .acc_in(acc0), .acc_valid(av0), .out_data(od0),
    .out_c(c0), .out_a(a0), .out_valid(v0), .out_ready(rdy0), .out_last(l0), .busy(b0), .drop_err(e0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      acc_in[k*20 +: 20] = el[k];
      if (k < n) begin
        e.d = ex[k];
        e.c = 2'(k / 4);
        e.a = 2'(k % 4);
        e.l = k == 15;
        sb.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t cur, e;
    cur = {out_data, out_c, out_a, out_last};
    if (!rst && stall_q && out_valid) check("stall_hold", 32'(cur), 32'(held));
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_beat", 32'(cur), 32'hFFFFFFFF);
      else begin
        e = sb.pop_front();
        check("beat", 32'(cur), 32'(e));
      end
    end
    stall_q <= !rst && out_valid && !out_ready;
    held <= cur;
  end

  initial begin
    rst = 1; acc_valid = 0; out_ready = 1; acc_in = '0; acc0 = '0; av0 = 0; rdy0 = 1;
    step(); step();
    rst = 0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_drop", 32'(drop_err), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_c", 32'(out_c), 0);
    check("rst_a", 32'(out_a), 0);
    // basic stream: element 16*k -> k
    for (int k = 0; k < 16; k++) begin el[k] = 20'(16*k); ex[k] = 8'(k); end
    load(16); acc_valid = 1; step(); acc_valid = 0;
    check("lat_valid", 32'(out_valid), 1);
    check("lat_busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) step();
    check("basic_end", 32'(out_valid), 0);
    check("basic_sb", 32'(sb.size()), 0);
    // rounding and saturation
    for (int k = 0; k < 16; k++) begin el[k] = '0; ex[k] = '0; end
    el[0] = 20'd23; ex[0] = 8'd1;
    el[1] = 20'd24; ex[1] = 8'd2;
    el[2] = 20'd4087; ex[2] = 8'd255;
    el[3] = 20'd4088; ex[3] = 8'd255;
    el[4] = 20'hFFFFF; ex[4] = 8'd255;
    load(16); acc_valid = 1; step(); acc_valid = 0;
    for (int i = 0; i < 16; i++) step();
    check("round_sb", 32'(sb.size()), 0);
    // backpressure
    for (int k = 0; k < 16; k++) begin el[k] = 20'(80*k); ex[k] = 8'(5*k); end
    load(16); acc_valid = 1; out_ready = 0; step(); acc_valid = 0;
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (!out_valid && sb.size() == 0) break;
    end
    out_ready = 1;
    check("bp_drained", 32'(sb.size()), 0);
    check("bp_idle", 32'(out_valid), 0);
    // back-to-back
    for (int k = 0; k < 16; k++) begin el[k] = 20'(16*k); ex[k] = 8'(k); end
    load(16); acc_valid = 1; step(); acc_valid = 0;
    for (int i = 0; i < 15; i++) step();
    for (int k = 0; k < 16; k++) begin el[k] = 20'(16*(100+k)); ex[k] = 8'(100+k); end
    load(16); acc_valid = 1; step(); acc_valid = 0;
    check("b2b_valid", 32'(out_valid), 1);
    check("b2b_c", 32'(out_c), 0);
    check("b2b_a", 32'(out_a), 0);
    check("b2b_drop", 32'(drop_err), 0);
    for (int i = 0; i < 16; i++) step();
    check("b2b_end", 32'(out_valid), 0);
    check("b2b_sb", 32'(sb.size()), 0);
    // drop at beat 5
    for (int k = 0; k < 16; k++) begin el[k] = 20'(16*(200+k)); ex[k] = 8'(200+k); end
    load(16); acc_valid = 1; step(); acc_valid = 0;
    for (int i = 0; i < 5; i++) step();
    for (int k = 0; k < 16; k++) begin el[k] = 20'hFFFFF; end
    load(0); acc_valid = 1; step(); acc_valid = 0;
    check("drop_set", 32'(drop_err), 1);
    for (int i = 0; i < 10; i++) step();
    check("drop_end", 32'(out_valid), 0);
    check("drop_sticky", 32'(drop_err), 1);
    step(); step(); step();
    check("drop_no_tile", 32'(out_valid), 0);
    check("drop_sb", 32'(sb.size()), 0);
    // reset at beat 7
    for (int k = 0; k < 16; k++) begin el[k] = 20'(16*k); ex[k] = 8'(k); end
    load(7); acc_valid = 1; step(); acc_valid = 0;
    for (int i = 0; i < 7; i++) step();
    rst = 1; step(); rst = 0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_drop", 32'(drop_err), 0);
    check("mid_rst_sb", 32'(sb.size()), 0);
    for (int k = 0; k < 16; k++) begin el[k] = 20'(16*(50+k)); ex[k] = 8'(50+k); end
    load(16); acc_valid = 1; step(); acc_valid = 0;
    check("restart_c", 32'(out_c), 0);
    check("restart_a", 32'(out_a), 0);
    for (int i = 0; i < 16; i++) step();
    check("restart_sb", 32'(sb.size()), 0);
    // SHIFT=0 instance
    acc0[0 +: 20] = 20'd200; acc0[20 +: 20] = 20'd300;
    av0 = 1; step(); av0 = 0;
    check("s0_valid", 32'(v0), 1);
    check("s0_data0", 32'(od0), 200);
    step();
    check("s0_data1", 32'(od0), 255);
    check("s0_a1", 32'(a0), 1);
    check("s0_c1", 32'(c0), 0);
    check("s0_last", 32'(l0), 0);
    check("s0_busy", 32'(b0), 1);
    check("s0_drop", 32'(e0), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simd_drain.md
# simd_drain

Output drain stage that sits directly downstream of the SIMD cell array and consumes its per-tile product accumulators. When the array signals a completed tile, the block snapshots the full DIM_C×DIM_A accumulator bank in one cycle. It then requantizes each element (round-half-up, right shift, unsigned saturate) and streams the elements out one per beat on a valid/ready interface, so the array can start its next tile immediately.

## Interface
Parameters:
- DIM_A, 4, input lanes per weight (inner element index a)
- DIM_C, 4, weight lanes (outer element index c)
- IN_W, 20, accumulator element width (ACC_WIDTH+DIM_B); unsigned
- OUT_W, 8, output element width; unsigned
- SHIFT, 4, requantization right-shift amount, 0 ≤ SHIFT < IN_W

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- acc_in  in  DIM_C*DIM_A*IN_W  accumulator bank; element (c,a) at bits [(c*DIM_A+a)*IN_W +: IN_W]
- acc_valid  in  1  single-cycle strobe: acc_in holds a completed tile this cycle
- out_data  out  OUT_W  requantized element
- out_c  out  $clog2(DIM_C) (min 1)  weight-lane index of out_data
- out_a  out  $clog2(DIM_A) (min 1)  input-lane index of out_data
- out_valid  out  1  out_data/out_c/out_a/out_last valid
- out_ready  in  1  downstream accepts the beat
- out_last  out  1  final element of the tile
- busy  out  1  snapshot held, stream in progress
- drop_err  out  1  sticky: an acc_valid was refused

## Operation
- FSM with two states: IDLE and STREAM. Reset state is IDLE.
- IDLE: when acc_valid=1, capture all of acc_in into the snapshot register, set element index to 0 and go to STREAM.
- STREAM: present element idx = c*DIM_A+a. Order is c outer, a inner: (0,0),(0,1)…(0,DIM_A-1),(1,0)…
- A handshake occurs when out_valid & out_ready. On a handshake, idx increments.
- On the handshake of idx = DIM_A*DIM_C-1 (out_last=1):
  - if acc_valid=1 in the same cycle, capture the new tile, reset idx to 0 and stay in STREAM (back-to-back, no bubble);
  - otherwise go to IDLE.
- acc_valid in STREAM without a final handshake in that cycle: the tile is dropped, drop_err is set, and the snapshot and stream are unaffected. drop_err is cleared only by rst.
- Requantization, per element v (IN_W bits):
  - if SHIFT>0: r = (v + 2^(SHIFT-1)) >> SHIFT, computed at IN_W+1 bits so the add cannot overflow;
  - if SHIFT=0: r = v.
  - out_data = (r > 2^OUT_W-1) ? 2^OUT_W-1 : r[OUT_W-1:0].
- out_valid = (state==STREAM); busy = out_valid.
- out_last = out_valid & (idx == DIM_A*DIM_C-1).
- While out_valid=1 and out_ready=0, out_data, out_c, out_a and out_last hold stable. The snapshot is never altered mid-tile.

## Timing
- Reset values (cycle after rst high): state IDLE; out_valid 0, busy 0, out_last 0, drop_err 0, out_data 0, out_c 0, out_a 0; snapshot cleared to 0.
- rst mid-stream aborts the tile immediately. There is no partial flush.
- Latency: acc_valid sampled at edge t gives out_valid=1 with element (0,0) after edge t, i.e. visible in cycle t+1.
- Throughput: one element per cycle with out_ready held high. A tile takes DIM_A*DIM_C cycles, 16 with default parameters.
- out_data is driven combinationally from the snapshot register and idx; there is no combinational path from out_ready to out_valid or out_data.
- acc_in is sampled only on the capture edge and may change freely at other times.

## Test plan
- Basic stream: defaults, SHIFT=4, element (c,a) = 16*(4c+a), one acc_valid pulse, out_ready=1 → 16 beats with out_data = 0,1,…,15 in order (0,0)…(3,3); out_last only on beat 16; out_valid drops the next cycle.
- Rounding and saturation: elements 23, 24, 4087, 4088, 0xFFFFF → out_data 1, 2, 255, 255, 255. Second run with SHIFT=0 and element 200 → 200.
- Backpressure: toggle out_ready pseudo-randomly → every element is delivered exactly once and in order; outputs are stable on every cycle with valid=1 and ready=0.
- Back-to-back: pulse acc_valid on the same cycle as the final handshake → the next cycle shows element (0,0) of the new tile with no idle cycle, and drop_err stays 0.
- Drop: pulse acc_valid at beat 5 of a stream → drop_err=1 and stays set; the current tile completes with unchanged data; no second tile is emitted.
- Reset mid-stream: assert rst at beat 7 → the next cycle shows out_valid=0, busy=0, drop_err=0; a new acc_valid then streams from (0,0).
